alu_exec_unit: RTL

//  Multi-cycle execute-stage ALU that consumes the 4-bit Operation code and two operands.
//  AND/OR/ADD/SUB complete in one cycle. SLL/SRL/MUL iterate one step per cycle.
//  A start/done handshake lets the multi-cycle datapath controller stall on busy.

---
 rtl/alu_ops_pkg.sv | 19 +
 rtl/alu_iter_core.sv | 59 +++++
 rtl/alu_exec_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_ops_pkg.sv
// Opcodes and FSM state encoding shared by the execute-stage ALU and
// by every block that produces an Operation code.
package alu_ops_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath for SLL/SRL/MUL: one shift or shift-add step per cycle.
// next_acc is the accumulator value the current step produces.
module alu_iter_core
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] next_acc
);

    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW:0]     count;

    always_comb begin
        next_acc = acc;
        case (op_q)
            OP_SLL:  next_acc = acc << 1;
            OP_SRL:  next_acc = acc >> 1;
            OP_MUL:  next_acc = mplier[0] ? acc + mcand : acc;
            default: next_acc = acc;
        endcase
    end

    assign last = (count == (SHW+1)'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            op_q   <= op;
            acc    <= (op == OP_MUL) ? '0 : a;
            mcand  <= a;
            mplier <= b;
            count  <= (op == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, b[SHW-1:0]};
        end else if (step) begin
            acc    <= next_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - (SHW+1)'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU: 1-cycle logic/add/sub, iterative SLL/SRL/MUL,
// start/ready/done handshake with registered result, zero and illegal flags.
module alu_exec_unit
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_t           state;
    logic             accept;
    logic             core_last;
    logic [WIDTH-1:0] core_acc;
    logic [WIDTH-1:0] fast_res;
    logic             fast_op;

    assign accept = (state == ST_IDLE) && start && ready;

    always_comb begin
        fast_res = '0;
        fast_op  = 1'b1;
        case (Operation)
            OP_AND:  fast_res = a & b;
            OP_OR:   fast_res = a | b;
            OP_ADD:  fast_res = a + b;
            OP_SUB:  fast_res = a - b;
            default: fast_op = 1'b0;
        endcase
    end

    alu_iter_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state == ST_ITER),
        .op       (Operation),
        .a        (a),
        .b        (b),
        .last     (core_last),
        .next_acc (core_acc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        ready <= 1'b0;
                        if (fast_op) begin
                            result  <= fast_res;
                            zero    <= (fast_res == '0);
                            illegal <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_FIN;
                        end else if ((Operation == OP_SLL || Operation == OP_SRL)
                                     && b[SHW-1:0] == '0) begin
                            result  <= a;
                            zero    <= (a == '0);
                            illegal <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_FIN;
                        end else if (Operation == OP_SLL || Operation == OP_SRL
                                     || Operation == OP_MUL) begin
                            busy  <= 1'b1;
                            state <= ST_ITER;
                        end else begin
                            result  <= '0;
                            zero    <= 1'b1;
                            illegal <= 1'b1;
                            done    <= 1'b1;
                            state   <= ST_FIN;
                        end
                    end
                end
                ST_ITER: begin
                    // Result is taken from the final step's output so it lands on the FIN-entry edge.
                    if (core_last) begin
                        result  <= core_acc;
                        zero    <= (core_acc == '0);
                        illegal <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
